// File: rtl/scanned_bcd_display_pkg.sv
// Shared constants and types for the scanned three-digit BCD display driver.
// Segment patterns are active-high with bit0 = a ... bit6 = g.
package scanned_bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam int PHASE_COUNT = 16;
    localparam int NUM_DIGITS  = 3;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/scanned_bcd_display_if.sv
// Digit inputs from the counting stage and the multiplexed pin outputs.
// master = upstream/board side, slave = the display driver.
interface scanned_bcd_display_if;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [2:0] DP;
    logic       BLANK_LZ;
    logic [3:0] BRIGHT;
    logic [7:0] SEG;
    logic [2:0] DIGIT;
    logic       FRAME_TICK;

    modport master (
        output units, tens, hundreds, DP, BLANK_LZ, BRIGHT,
        input  SEG, DIGIT, FRAME_TICK
    );

    modport slave (
        input  units, tens, hundreds, DP, BLANK_LZ, BRIGHT,
        output SEG, DIGIT, FRAME_TICK
    );
endinterface

// File: rtl/scanned_bcd_display_bcd_seg_decoder.sv
// Combinational BCD to active-high a..g pattern; non-decimal codes show a dash.
module bcd_seg_decoder
    import scanned_bcd_display_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_pattern
);
    always_comb begin
        o_pattern = SEG_DASH;
        case (i_code)
            4'd0: o_pattern = SEG_0;
            4'd1: o_pattern = SEG_1;
            4'd2: o_pattern = SEG_2;
            4'd3: o_pattern = SEG_3;
            4'd4: o_pattern = SEG_4;
            4'd5: o_pattern = SEG_5;
            4'd6: o_pattern = SEG_6;
            4'd7: o_pattern = SEG_7;
            4'd8: o_pattern = SEG_8;
            4'd9: o_pattern = SEG_9;
            default: o_pattern = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/scanned_bcd_display.sv
// Time-multiplexed three-digit common-anode driver with frame-coherent input
// snapshots, leading-zero blanking, decimal points and PWM brightness.
module scanned_bcd_display
    import scanned_bcd_display_pkg::*;
#(
    parameter int SUB_TICKS = 750
) (
    input  logic                  CLK,
    input  logic                  RST,
    scanned_bcd_display_if.slave  bus
);
    localparam int TW = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;

    logic [TW-1:0] r_tick;
    logic [3:0]    r_phase;
    digit_idx_t    r_digit;

    logic [3:0]    r_units_s;
    logic [3:0]    r_tens_s;
    logic [3:0]    r_hundreds_s;
    logic [2:0]    r_dp_s;
    logic          r_blank_lz_s;
    logic [3:0]    r_bright_s;

    logic [7:0]    r_seg;
    logic [2:0]    r_digit_n;
    logic          r_frame_tick;

    logic          w_tick_wrap;
    logic          w_phase_wrap;
    logic          w_snap;
    logic          w_window;
    logic [3:0]    w_code;
    logic          w_dp;
    logic          w_blank;
    logic [6:0]    w_pattern;
    logic [NUM_DIGITS-1:0] w_digit_en;

    assign w_tick_wrap  = (r_tick == TW'(SUB_TICKS - 1));
    assign w_phase_wrap = (r_phase == 4'(PHASE_COUNT - 1));
    assign w_snap       = (r_tick == '0) && (r_phase == 4'd0) && (r_digit == 2'd0);
    // Phase 0 is never lit so consecutive digits are separated by a dead phase.
    assign w_window     = (r_phase != 4'd0) && (r_phase <= r_bright_s);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_sel
            assign w_digit_en[gi] = (r_digit == digit_idx_t'(gi));
        end
    endgenerate

    always_comb begin
        w_code  = r_units_s;
        w_dp    = r_dp_s[0];
        w_blank = 1'b0;
        case (r_digit)
            2'd1: begin
                w_code  = r_tens_s;
                w_dp    = r_dp_s[1];
                w_blank = r_blank_lz_s && (r_hundreds_s == 4'd0) && (r_tens_s == 4'd0);
            end
            2'd2: begin
                w_code  = r_hundreds_s;
                w_dp    = r_dp_s[2];
                w_blank = r_blank_lz_s && (r_hundreds_s == 4'd0);
            end
            default: ;
        endcase
    end

    bcd_seg_decoder u_decoder (
        .i_code    (w_code),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick       <= '0;
            r_phase      <= 4'd0;
            r_digit      <= 2'd0;
            r_units_s    <= 4'd0;
            r_tens_s     <= 4'd0;
            r_hundreds_s <= 4'd0;
            r_dp_s       <= 3'd0;
            r_blank_lz_s <= 1'b0;
            r_bright_s   <= 4'd0;
            r_seg        <= 8'hFF;
            r_digit_n    <= 3'b111;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_tick_wrap) begin
                r_tick <= '0;
                if (w_phase_wrap) begin
                    r_phase <= 4'd0;
                    r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
                end else begin
                    r_phase <= r_phase + 4'd1;
                end
            end else begin
                r_tick <= r_tick + 1'b1;
            end

            if (w_snap) begin
                r_units_s    <= bus.units;
                r_tens_s     <= bus.tens;
                r_hundreds_s <= bus.hundreds;
                r_dp_s       <= bus.DP;
                r_blank_lz_s <= bus.BLANK_LZ;
                r_bright_s   <= bus.BRIGHT;
            end
            r_frame_tick <= w_snap;

            if (w_window) begin
                r_digit_n <= ~w_digit_en;
                r_seg     <= {~w_dp, ~(w_blank ? SEG_OFF : w_pattern)};
            end else begin
                r_digit_n <= 3'b111;
                r_seg     <= 8'hFF;
            end
        end
    end

    assign bus.SEG        = r_seg;
    assign bus.DIGIT      = r_digit_n;
    assign bus.FRAME_TICK = r_frame_tick;
endmodule

// File: tb/tb_scanned_bcd_display.sv
// Directed bench for scanned_bcd_display with a 4-cycle sub-phase (192-cycle frame).
module tb_scanned_bcd_display;
    localparam int ST    = 4;
    localparam int FRAME = 48 * ST;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    scanned_bcd_display_if bus ();

    scanned_bcd_display #(.SUB_TICKS(ST)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench on the first cycle of a frame whose snapshot was taken
    // after the call started, i.e. with the inputs currently applied.
    task automatic sync_frame(input string name);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            step();
            if (bus.FRAME_TICK === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_sync: FRAME_TICK not seen within %0d cycles", name, 2 * FRAME);
        end
    endtask

    task automatic set_inputs(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                              input logic [2:0] dp, input logic blz, input logic [3:0] br);
        bus.hundreds = h;
        bus.tens     = t;
        bus.units    = u;
        bus.DP       = dp;
        bus.BLANK_LZ = blz;
        bus.BRIGHT   = br;
    endtask

    task automatic test_reset();
        int gap;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.FRAME_TICK, bus.DIGIT, bus.SEG} !== {1'b0, 3'b111, 8'hFF}) begin
                errors++;
                $display("FAIL reset_hold c=%0d: got ft=%b dig=%b seg=%h want ft=0 dig=111 seg=FF",
                         c, bus.FRAME_TICK, bus.DIGIT, bus.SEG);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.FRAME_TICK !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_tick: got %b want 1", bus.FRAME_TICK);
        end
        gap = 0;
        for (int n = 1; n <= 2 * FRAME && gap == 0; n++) begin
            step();
            if (bus.FRAME_TICK === 1'b1) gap = n;
        end
        checks++;
        if (gap != FRAME) begin
            errors++;
            $display("FAIL reset_tick_period: got %0d want %0d", gap, FRAME);
        end
        $display("test_reset: tick period %0d cycles", gap);
    endtask

    task automatic test_display_123();
        logic [7:0]  segs [3];
        logic [11:0] obs, exp;
        int d, ph;
        segs[0] = 8'hB0; segs[1] = 8'hA4; segs[2] = 8'hF9;
        set_inputs(4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 4'd15);
        sync_frame("d123");
        for (int k = 0; k < FRAME; k++) begin
            d = k / (16 * ST); ph = (k / ST) % 16;
            exp = {(k == 0), 3'b111, 8'hFF};
            if (ph >= 1) exp = {(k == 0), ~(3'b001 << d), segs[d]};
            obs = {bus.FRAME_TICK, bus.DIGIT, bus.SEG};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL d123 k=%0d: got %h want %h", k, obs, exp);
            end
            step();
        end
        $display("test_display_123: frame done");
    endtask

    task automatic test_blank_lz();
        logic [7:0]  segs [3];
        logic [11:0] obs, exp;
        int d, ph;
        segs[0] = 8'hF8; segs[1] = 8'hFF; segs[2] = 8'h7F;
        set_inputs(4'd0, 4'd0, 4'd7, 3'b100, 1'b1, 4'd15);
        sync_frame("lz");
        for (int k = 0; k < FRAME; k++) begin
            d = k / (16 * ST); ph = (k / ST) % 16;
            exp = {(k == 0), 3'b111, 8'hFF};
            if (ph >= 1) exp = {(k == 0), ~(3'b001 << d), segs[d]};
            obs = {bus.FRAME_TICK, bus.DIGIT, bus.SEG};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lz k=%0d: got %h want %h", k, obs, exp);
            end
            step();
        end
        $display("test_blank_lz: frame done");
    endtask

    task automatic test_brightness();
        logic [7:0]  segs [3];
        logic [11:0] obs, exp;
        int d, ph;
        int lit [3];
        segs[0] = 8'hB0; segs[1] = 8'hA4; segs[2] = 8'hF9;
        set_inputs(4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 4'd0);
        sync_frame("br0");
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (bus.DIGIT !== 3'b111 || bus.SEG !== 8'hFF) begin
                errors++;
                $display("FAIL br0 k=%0d: got dig=%b seg=%h want dig=111 seg=FF", k, bus.DIGIT, bus.SEG);
            end
            step();
        end
        bus.BRIGHT = 4'd3;
        sync_frame("br3");
        lit[0] = 0; lit[1] = 0; lit[2] = 0;
        for (int k = 0; k < FRAME; k++) begin
            d = k / (16 * ST); ph = (k / ST) % 16;
            exp = {(k == 0), 3'b111, 8'hFF};
            if (ph >= 1 && ph <= 3) exp = {(k == 0), ~(3'b001 << d), segs[d]};
            obs = {bus.FRAME_TICK, bus.DIGIT, bus.SEG};
            if (bus.DIGIT !== 3'b111) lit[d]++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL br3 k=%0d: got %h want %h", k, obs, exp);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lit[i] != 3 * ST) begin
                errors++;
                $display("FAIL br3_lit digit=%0d: got %0d want %0d", i, lit[i], 3 * ST);
            end
        end
        $display("test_brightness: lit cycles %0d %0d %0d", lit[0], lit[1], lit[2]);
    endtask

    task automatic test_midframe_change();
        logic [7:0]  segs [3];
        logic [11:0] obs, exp;
        int d, ph;
        segs[0] = 8'hB0; segs[1] = 8'hA4; segs[2] = 8'hF9;
        set_inputs(4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 4'd15);
        sync_frame("mid");
        for (int f = 0; f < 2; f++) begin
            if (f == 1) segs[0] = 8'hBF;
            for (int k = 0; k < FRAME; k++) begin
                d = k / (16 * ST); ph = (k / ST) % 16;
                exp = {(k == 0), 3'b111, 8'hFF};
                if (ph >= 1) exp = {(k == 0), ~(3'b001 << d), segs[d]};
                obs = {bus.FRAME_TICK, bus.DIGIT, bus.SEG};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL mid f=%0d k=%0d: got %h want %h", f, k, obs, exp);
                end
                if (f == 0 && k == 20) bus.units = 4'd12;
                step();
            end
        end
        $display("test_midframe_change: two frames done");
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  segs [3];
        logic [11:0] obs, exp;
        int d, ph;
        segs[0] = 8'hB0; segs[1] = 8'hA4; segs[2] = 8'hF9;
        set_inputs(4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 4'd15);
        sync_frame("rstmid");
        for (int k = 0; k < 80; k++) step();
        checks++;
        if ({bus.DIGIT, bus.SEG} !== {3'b101, 8'hA4}) begin
            errors++;
            $display("FAIL rstmid_pre: got dig=%b seg=%h want dig=101 seg=A4", bus.DIGIT, bus.SEG);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({bus.FRAME_TICK, bus.DIGIT, bus.SEG} !== {1'b0, 3'b111, 8'hFF}) begin
            errors++;
            $display("FAIL rstmid_edge: got ft=%b dig=%b seg=%h want ft=0 dig=111 seg=FF",
                     bus.FRAME_TICK, bus.DIGIT, bus.SEG);
        end
        rst = 1'b0;
        step();
        for (int k = 0; k < FRAME; k++) begin
            d = k / (16 * ST); ph = (k / ST) % 16;
            exp = {(k == 0), 3'b111, 8'hFF};
            if (ph >= 1) exp = {(k == 0), ~(3'b001 << d), segs[d]};
            obs = {bus.FRAME_TICK, bus.DIGIT, bus.SEG};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rstmid k=%0d: got %h want %h", k, obs, exp);
            end
            step();
        end
        $display("test_reset_midframe: restarted frame done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_inputs(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0);
        test_reset();
        test_display_123();
        test_blank_lz();
        test_brightness();
        test_midframe_change();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
